// File: rtl/sha_k_stream.sv
// rtl/sha_k_stream.sv - SHA-2 K constant streamer, 1/2/4 consecutive constants per beat
// Optional per-lane even parity on k_par: define SHA_K_PARITY_EN.
module sha_k_stream #(
   parameter int WORD_W = 32,
   parameter int LANES  = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    k_ready,
   output logic                    k_valid,
   output logic [LANES*WORD_W-1:0] k_data,
   output logic [6:0]              k_round,
   output logic                    k_last,
   output logic                    busy,
   output logic                    done,
   output logic [LANES-1:0]        k_par
);
   localparam int         ROUNDS = (WORD_W == 64) ? 80 : 64;
   localparam logic [6:0] LAST_R = 7'(ROUNDS - LANES);
   localparam logic [6:0] STEP   = 7'(LANES);

   // SHA-512 K; SHA-256 K[i] is the upper half of each entry
   localparam logic [63:0] K_TAB [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                  state_q;
   logic [6:0]              round_q, base_d, idx;
   logic                    valid_q, last_q, busy_q, done_q, load;
   logic [LANES*WORD_W-1:0] data_q, data_d;

   function automatic logic [WORD_W-1:0] lane_word(input logic [6:0] i);
      logic [63:0] t;
      t = (i < 7'(ROUNDS)) ? K_TAB[i] : 64'h0;
      return WORD_W'(t >> (64 - WORD_W));
   endfunction

   // The lookahead group is fetched one beat early so every output stays registered
   always_comb begin
      load   = (state_q == IDLE) ? start
                                 : (!abort && valid_q && k_ready && !last_q);
      base_d = (state_q == IDLE) ? 7'd0 : round_q + STEP;
      idx    = '0;
      data_d = '0;
      for (int j = 0; j < LANES; j++) begin
         idx = base_d + 7'(j);
         data_d[j*WORD_W +: WORD_W] = lane_word(idx);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         round_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            data_q  <= data_d;
            round_q <= base_d;
            last_q  <= (base_d == LAST_R);
         end
         case (state_q)
            IDLE: if (start) begin
               state_q <= STREAM;
               valid_q <= 1'b1;
               busy_q  <= 1'b1;
            end
            STREAM: if (abort) begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               round_q <= '0;
               last_q  <= 1'b0;
            end else if (valid_q && k_ready && last_q) begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               last_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         endcase
      end
   end

`ifdef SHA_K_PARITY_EN
   logic [LANES-1:0] par_q, par_d;

   always_comb begin
      par_d = '0;
      for (int j = 0; j < LANES; j++) par_d[j] = ^data_d[j*WORD_W +: WORD_W];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) par_q <= '0;
      else if (load) par_q <= par_d;
   end

   assign k_par = par_q;
`else
   assign k_par = '0;
`endif

   assign k_valid = valid_q;
   assign k_data  = data_q;
   assign k_round = round_q;
   assign k_last  = last_q;
   assign busy    = busy_q;
   assign done    = done_q;
endmodule

// File: tb/tb_sha_k_stream.sv
// tb/tb_sha_k_stream.sv - directed bench for sha_k_stream (W32/L1, W64/L1, W32/L2)
module tb_sha_k_stream;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, k_ready = 1'b0;
   always #5 clk = ~clk;

   logic v32, l32, b32, dn32; logic [31:0] d32; logic [6:0] r32; logic [0:0] p32;
   logic v64, l64, b64, dn64; logic [63:0] d64; logic [6:0] r64; logic [0:0] p64;
   logic v2,  l2,  b2,  dn2;  logic [63:0] d2;  logic [6:0] r2;  logic [1:0] p2;

   sha_k_stream #(.WORD_W(32), .LANES(1)) u_w32 (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .k_ready(k_ready),
      .k_valid(v32), .k_data(d32), .k_round(r32), .k_last(l32), .busy(b32), .done(dn32), .k_par(p32));
   sha_k_stream #(.WORD_W(64), .LANES(1)) u_w64 (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .k_ready(k_ready),
      .k_valid(v64), .k_data(d64), .k_round(r64), .k_last(l64), .busy(b64), .done(dn64), .k_par(p64));
   sha_k_stream #(.WORD_W(32), .LANES(2)) u_l2 (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .k_ready(k_ready),
      .k_valid(v2), .k_data(d2), .k_round(r2), .k_last(l2), .busy(b2), .done(dn2), .k_par(p2));

   logic [31:0] ref32 [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef struct {
      string       name;
      bit          lanes2;
      int          rnd;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs [8];

   int checks = 0, passes = 0;
   int er32, er64, er2, nb32, nb64, nb2, nd32, nd64, nd2;
   int lastc32, lastc64, lastc2, donec32, donec64, donec2;
   logic [63:0] cap64 [80];
   logic [63:0] cap2 [32];
   logic rdy_r;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [31:0] kref(input int i);
      return (i >= 0 && i < 64) ? ref32[i] : 32'h0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      er32 = 0; er64 = 0; er2 = 0; nb32 = 0; nb64 = 0; nb2 = 0; nd32 = 0; nd64 = 0; nd2 = 0;
      lastc32 = -10; lastc64 = -10; lastc2 = -10; donec32 = -20; donec64 = -20; donec2 = -20;
      foreach (cap64[i]) cap64[i] = '0;
      foreach (cap2[i]) cap2[i] = '0;
   endtask

   // Checks every visible beat against the reference order; rdy is the value driven for the next edge
   task automatic monitor(input logic rdy, input int cyc);
      if (v32) begin
         chk("w32_round", r32, er32);
         chk("w32_data", d32, kref(er32));
         chk("w32_last", l32, er32 == 63);
         chk("w32_busy", b32, 1'b1);
`ifdef SHA_K_PARITY_EN
         chk("w32_par", p32, ^kref(er32));
`else
         chk("w32_par", p32, 1'b0);
`endif
         if (rdy) begin nb32++; if (l32) lastc32 = cyc; er32++; end
      end
      if (dn32) begin nd32++; donec32 = cyc; end
      if (v64) begin
         chk("w64_round", r64, er64);
         chk("w64_last", l64, er64 == 79);
         if (er64 < 64) chk("w64_hi", d64[63:32], kref(er64));
         if (er64 < 80) cap64[er64] = d64;
         if (rdy) begin nb64++; if (l64) lastc64 = cyc; er64++; end
      end
      if (dn64) begin nd64++; donec64 = cyc; end
      if (v2) begin
         chk("l2_round", r2, er2);
         chk("l2_data", d2, {kref(er2 + 1), kref(er2)});
         chk("l2_last", l2, er2 == 62);
`ifdef SHA_K_PARITY_EN
         chk("l2_par", p2, {^kref(er2 + 1), ^kref(er2)});
`else
         chk("l2_par", p2, 2'b00);
`endif
         if (er2 < 64) cap2[er2/2] = d2;
         if (rdy) begin nb2++; if (l2) lastc2 = cyc; er2 += 2; end
      end
      if (dn2) begin nd2++; donec2 = cyc; end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_beats32"}, nb32, 64);
      chk({tag, "_beats64"}, nb64, 80);
      chk({tag, "_beats2"}, nb2, 32);
      chk({tag, "_done32"}, nd32, 1);
      chk({tag, "_done64"}, nd64, 1);
      chk({tag, "_done2"}, nd2, 1);
   endtask

   initial begin
      vecs[0] = '{"w64_r0",  1'b0, 0,  64'h428a2f98d728ae22};
      vecs[1] = '{"w64_r10", 1'b0, 10, 64'h243185be4ee4b28c};
      vecs[2] = '{"w64_r11", 1'b0, 11, 64'h550c7dc3d5ffb4e2};
      vecs[3] = '{"w64_r64", 1'b0, 64, 64'hca273eceea26619c};
      vecs[4] = '{"w64_r79", 1'b0, 79, 64'h6c44198c4a475817};
      vecs[5] = '{"l2_r0",   1'b1, 0,  64'h71374491_428a2f98};
      vecs[6] = '{"l2_r10",  1'b1, 10, 64'h550c7dc3_243185be};
      vecs[7] = '{"l2_r62",  1'b1, 62, 64'hc67178f2_bef9a3f7};

      repeat (3) tick;
      chk("rst_w32", {v32, d32, r32, l32, b32, dn32, p32}, 0);
      chk("rst_w64", {v64, d64, r64, l64, b64, dn64, p64}, 0);
      chk("rst_l2",  {v2, d2, r2, l2, b2, dn2, p2}, 0);
      reset_n = 1'b1;
      tick;
      chk("idle_no_valid", {v32, v64, v2}, 0);

      // Full-throughput stream; start re-asserted mid-stream and on the L2 last beat must be ignored
      clr;
      k_ready = 1'b1;
      start = 1'b1;
      tick;
      chk("start_latency", {v32, b32, r32}, {1'b1, 1'b1, 7'd0});
      for (int cyc = 0; cyc < 100; cyc++) begin
         monitor(1'b1, cyc);
         if (cyc == 32) chk("l2_start_ignored", {v2, b2, dn2}, 3'b001);
         start = (cyc < 3 || cyc == 31);
         tick;
      end
      chk_counts("full");
      chk("done_t32", donec32, lastc32 + 1);
      chk("done_t64", donec64, lastc64 + 1);
      chk("done_t2", donec2, lastc2 + 1);
      chk("end_idle", {v32, b32, v64, b64, v2, b2}, 0);
      for (int i = 0; i < 8; i++)
         chk(vecs[i].name, vecs[i].lanes2 ? cap2[vecs[i].rnd/2] : cap64[vecs[i].rnd], vecs[i].exp);

      // Backpressure at round 10, then abort at round 20 with k_ready high
      clr;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 0; c < 50 && !(v32 && r32 == 7'd10); c++) begin
         monitor(1'b1, c);
         tick;
      end
      chk("bp_reach10", {v32, r32}, {1'b1, 7'd10});
      k_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         monitor(1'b0, 0);
         chk("bp_hold", {d32, r32}, {32'h243185be, 7'd10});
         tick;
      end
      k_ready = 1'b1;
      monitor(1'b1, 0);
      tick;
      chk("bp_resume", {v32, r32, d32}, {1'b1, 7'd11, 32'h550c7dc3});
      for (int c = 0; c < 50 && r32 != 7'd20; c++) begin
         monitor(1'b1, c);
         tick;
      end
      chk("ab_reach20", {v32, r32}, {1'b1, 7'd20});
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_w32", {v32, b32, dn32, r32}, 0);
      chk("abort_others", {v64, b64, v2, b2}, 0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_quiet", {v32, dn32, v64, dn64, v2, dn2}, 0);
         tick;
      end
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_idle", {v32, b32, dn32}, 0);

      // Restart, then a full stream under random backpressure
      clr;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("restart_w32", {v32, r32, d32}, {1'b1, 7'd0, 32'h428a2f98});
      chk("restart_w64", d64, 64'h428a2f98d728ae22);
      for (int c = 0; c < 2000; c++) begin
         if (nd32 != 0 && nd64 != 0 && nd2 != 0) break;
         rdy_r = 1'($urandom_range(0, 1));
         k_ready = rdy_r;
         monitor(rdy_r, c);
         tick;
      end
      chk_counts("rand");

      // Asynchronous reset mid-stream at round 40
      clr;
      k_ready = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 0; c < 60 && r32 != 7'd40; c++) tick;
      chk("rst_reach40", {v32, r32}, {1'b1, 7'd40});
      #2 reset_n = 1'b0;
      #1;
      chk("async_w32", {v32, d32, r32, l32, b32, dn32, p32}, 0);
      chk("async_w64", {v64, d64, r64, l64, b64, dn64, p64}, 0);
      chk("async_l2",  {v2, d2, r2, l2, b2, dn2, p2}, 0);
      tick;
      reset_n = 1'b1;
      tick;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("post_rst_w32", {v32, r32, d32}, {1'b1, 7'd0, 32'h428a2f98});
`ifdef SHA_K_PARITY_EN
      chk("post_rst_par32", p32, 1'b1);
      chk("post_rst_par2", p2, 2'b01);
`else
      chk("post_rst_par32", p32, 1'b0);
      chk("post_rst_par2", p2, 2'b00);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
